// File: rtl/adc_sampler.sv
// adc_sampler: periodic ADC conversion sequencer and sample capture.
// Issues a start-of-conversion pulse every SAMPLE_PERIOD clocks and waits
// for the ADC end-of-conversion. It captures the synchronized ADC data and
// regenerates a fixed-width EOC strobe for downstream logic. A missing EOC
// within the period sets a sticky timeout flag.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-low
//   enable       : 1 = keep converting; 0 = stop after the current period
//   adc_din      : ADC parallel data (asynchronous)
//   adc_eoc      : ADC end-of-conversion (asynchronous, active high)
//   adc_soc      : start-of-conversion pulse, SOC_WIDTH cycles
//   sample       : last captured sample
//   sample_valid : one-cycle strobe when sample updates
//   eoc_out      : regenerated EOC, EOC_HOLD cycles per capture
//   timeout_err  : sticky conversion-timeout flag, cleared only by reset
//   sample_count : captured samples, wraps at 16 bits
module adc_sampler #(
    parameter int unsigned DATA_WIDTH_BITS = 8,
    parameter int unsigned SAMPLE_PERIOD   = 3000,
    parameter int unsigned SOC_WIDTH       = 4,
    parameter int unsigned EOC_HOLD        = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DATA_WIDTH_BITS-1:0] adc_din,
    input  logic                       adc_eoc,
    output logic                       adc_soc,
    output logic [DATA_WIDTH_BITS-1:0] sample,
    output logic                       sample_valid,
    output logic                       eoc_out,
    output logic                       timeout_err,
    output logic [15:0]                sample_count
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned HOLD_W = $clog2(EOC_HOLD + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] START    = 2'd1;
    localparam logic [1:0] WAIT_EOC = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    logic [1:0]                 state, state_next;
    logic [CNT_W-1:0]           pcnt, pcnt_next;
    logic [HOLD_W-1:0]          hold_cnt, hold_cnt_next;
    logic                       eoc_s1, eoc_s2, eoc_prev;
    logic [DATA_WIDTH_BITS-1:0] din_s1, din_s2;

    logic                       soc_next;
    logic [DATA_WIDTH_BITS-1:0] sample_next;
    logic                       sample_valid_next;
    logic                       eoc_out_next;
    logic                       timeout_next;
    logic [15:0]                count_next;

    logic eoc_rise;
    logic period_end;
    logic capture;
    logic [1:0] after_period;

    assign eoc_rise     = eoc_s2 & ~eoc_prev;
    assign period_end   = (pcnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign after_period = enable ? START : IDLE;

    // Next-state and registered-output logic
    always_comb begin
        state_next        = state;
        pcnt_next         = pcnt + CNT_W'(1);
        capture           = 1'b0;
        sample_next       = sample;
        sample_valid_next = 1'b0;
        timeout_next      = timeout_err;
        count_next        = sample_count;
        eoc_out_next      = eoc_out;
        hold_cnt_next     = hold_cnt;

        case (state)
            IDLE: begin
                pcnt_next = '0;
                if (enable) begin
                    state_next = START;
                end
            end
            START: begin
                if (pcnt == CNT_W'(SOC_WIDTH - 1)) begin
                    state_next = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                // A capture on the last period cycle still counts; no timeout
                if (eoc_rise) begin
                    capture    = 1'b1;
                    state_next = period_end ? after_period : HOLD;
                end else if (period_end) begin
                    timeout_next = 1'b1;
                    state_next   = after_period;
                end
            end
            HOLD: begin
                if (period_end) begin
                    state_next = after_period;
                end
            end
            default: state_next = IDLE;
        endcase

        if (period_end || state_next == IDLE) begin
            pcnt_next = '0;
        end

        if (capture) begin
            sample_next       = din_s2;
            sample_valid_next = 1'b1;
            count_next        = sample_count + 16'd1;
        end

        // Regenerated EOC: starts with the capture, never retriggers while high
        if (capture && !eoc_out) begin
            eoc_out_next  = 1'b1;
            hold_cnt_next = HOLD_W'(EOC_HOLD - 1);
        end else if (eoc_out) begin
            if (hold_cnt == '0) begin
                eoc_out_next = 1'b0;
            end else begin
                hold_cnt_next = hold_cnt - HOLD_W'(1);
            end
        end

        soc_next = (state_next == START);
    end

    // State, synchronizers and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pcnt         <= '0;
            hold_cnt     <= '0;
            eoc_s1       <= 1'b0;
            eoc_s2       <= 1'b0;
            eoc_prev     <= 1'b0;
            din_s1       <= '0;
            din_s2       <= '0;
            adc_soc      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            eoc_out      <= 1'b0;
            timeout_err  <= 1'b0;
            sample_count <= '0;
        end else begin
            state        <= state_next;
            pcnt         <= pcnt_next;
            hold_cnt     <= hold_cnt_next;
            eoc_s1       <= adc_eoc;
            eoc_s2       <= eoc_s1;
            eoc_prev     <= eoc_s2;
            din_s1       <= adc_din;
            din_s2       <= din_s1;
            adc_soc      <= soc_next;
            sample       <= sample_next;
            sample_valid <= sample_valid_next;
            eoc_out      <= eoc_out_next;
            timeout_err  <= timeout_next;
            sample_count <= count_next;
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed bench for adc_sampler with period 100, SOC 4, EOC hold 8.
// Expected captures are queued when the EOC is driven and checked when
// sample_valid appears; adc_soc rise spacing is checked on every rise.
module tb_adc_sampler;

    localparam int unsigned PERIOD = 100;

    typedef struct packed {
        logic [7:0]  smp;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  adc_din;
    logic        adc_eoc;
    logic        adc_soc;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        eoc_out;
    logic        timeout_err;
    logic [15:0] sample_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   soc_rises = 0;
    int   last_rise = 0;
    bit   have_last = 0;
    logic soc_prev = 1'b0;
    int   exp_count = 0;
    exp_t q[$];

    adc_sampler #(
        .DATA_WIDTH_BITS(8),
        .SAMPLE_PERIOD  (PERIOD),
        .SOC_WIDTH      (4),
        .EOC_HOLD       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .adc_din     (adc_din),
        .adc_eoc     (adc_eoc),
        .adc_soc     (adc_soc),
        .sample      (sample),
        .sample_valid(sample_valid),
        .eoc_out     (eoc_out),
        .timeout_err (timeout_err),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: scoreboard pop on sample_valid, soc spacing check
    task automatic observe();
        exp_t e;
        if (sample_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(sample_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("sb_sample", 32'(sample), 32'(e.smp));
                chk("sb_count", 32'(sample_count), 32'(e.cnt));
                chk("sb_eoc_out", 32'(eoc_out), 32'h1);
            end
        end
        if (adc_soc === 1'b1 && soc_prev !== 1'b1) begin
            if (have_last) chk("soc_spacing", 32'(cyc - last_rise), 32'(PERIOD));
            last_rise = cyc;
            have_last = 1;
            soc_rises++;
        end
        soc_prev = adc_soc;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            observe();
        end
    endtask

    task automatic wait_soc_rise(input string tag);
        int r0;
        int n;
        r0 = soc_rises;
        n = 0;
        while (soc_rises == r0 && n < 300) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(soc_rises != r0), 32'h1);
    endtask

    task automatic drive_eoc(input logic [7:0] d);
        adc_din = d;
        adc_eoc = 1'b1;
        exp_count++;
        q.push_back('{smp: d, cnt: 16'(exp_count)});
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        enable  = 1'b0;
        adc_eoc = 1'b0;
        adc_din = 8'h00;
        tick(2);
        chk("rst_soc", 32'(adc_soc), 32'h0);
        chk("rst_sample", 32'(sample), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_eoc_out", 32'(eoc_out), 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        chk("rst_count", 32'(sample_count), 32'h0);
        q.delete();
        exp_count = 0;
        have_last = 0;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal periodic conversions, EOC 20 cycles after SOC
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_soc_rise("t1_soc");
            tick(20);
            drive_eoc(8'h5A);
            tick(2);
            chk("t1_valid_early", 32'(sample_valid), 32'h0);
            tick(1);
            chk("t1_valid_lat3", 32'(sample_valid), 32'h1);
            chk("t1_sample", 32'(sample), 32'h5A);
            tick(2);
            adc_eoc = 1'b0;
            tick(5);
            chk("t1_eoc_out_last", 32'(eoc_out), 32'h1);
            tick(1);
            chk("t1_eoc_out_off", 32'(eoc_out), 32'h0);
            chk("t1_count", 32'(sample_count), 32'(k + 1));
        end
        wait_soc_rise("t1_soc_final");
        chk("t1_queue_empty", 32'(q.size()), 32'h0);

        // No EOC: timeout at period end, restart, count unchanged
        do_reset();
        enable = 1'b1;
        wait_soc_rise("t2_soc");
        tick(99);
        chk("t2_timeout_before", 32'(timeout_err), 32'h0);
        tick(1);
        chk("t2_timeout_set", 32'(timeout_err), 32'h1);
        chk("t2_soc_again", 32'(adc_soc), 32'h1);
        chk("t2_count", 32'(sample_count), 32'h0);
        tick(50);
        chk("t2_timeout_sticky", 32'(timeout_err), 32'h1);

        // EOC rise inside START ignored, real EOC at cycle 30 captured
        do_reset();
        enable = 1'b1;
        wait_soc_rise("t3_soc");
        drive_eoc(8'h11);
        void'(q.pop_back());
        exp_count--;
        tick(2);
        adc_eoc = 1'b0;
        tick(28);
        drive_eoc(8'hC3);
        tick(3);
        chk("t3_valid", 32'(sample_valid), 32'h1);
        chk("t3_sample", 32'(sample), 32'hC3);
        tick(2);
        adc_eoc = 1'b0;
        tick(60);
        chk("t3_count_once", 32'(sample_count), 32'h1);
        chk("t3_sample_hold", 32'(sample), 32'hC3);

        // Enable dropped mid-conversion: capture completes, then idle
        do_reset();
        enable = 1'b1;
        wait_soc_rise("t4_soc");
        tick(10);
        enable = 1'b0;
        tick(10);
        drive_eoc(8'h77);
        tick(3);
        chk("t4_valid", 32'(sample_valid), 32'h1);
        tick(2);
        adc_eoc = 1'b0;
        begin
            int r0;
            r0 = soc_rises;
            tick(200);
            chk("t4_no_more_soc", 32'(soc_rises - r0), 32'h0);
        end
        chk("t4_soc_low", 32'(adc_soc), 32'h0);
        chk("t4_count", 32'(sample_count), 32'h1);
        chk("t4_timeout", 32'(timeout_err), 32'h0);

        // One-cycle reset during WAIT_EOC, then a clean restart
        do_reset();
        enable = 1'b1;
        wait_soc_rise("t5_soc");
        tick(20);
        drive_eoc(8'h5A);
        tick(5);
        adc_eoc = 1'b0;
        wait_soc_rise("t5_soc2");
        tick(40);
        reset = 1'b0;
        tick(1);
        chk("t5_rst_soc", 32'(adc_soc), 32'h0);
        chk("t5_rst_sample", 32'(sample), 32'h0);
        chk("t5_rst_valid", 32'(sample_valid), 32'h0);
        chk("t5_rst_eoc_out", 32'(eoc_out), 32'h0);
        chk("t5_rst_timeout", 32'(timeout_err), 32'h0);
        chk("t5_rst_count", 32'(sample_count), 32'h0);
        exp_count = 0;
        have_last = 0;
        reset = 1'b1;
        wait_soc_rise("t5_restart");
        tick(20);
        drive_eoc(8'h3C);
        tick(5);
        adc_eoc = 1'b0;
        wait_soc_rise("t5_period");
        chk("t5_count", 32'(sample_count), 32'h1);
        chk("t5_sample", 32'(sample), 32'h3C);

        // EOC rise on the last period cycle: capture wins over timeout
        do_reset();
        enable = 1'b1;
        wait_soc_rise("t6_soc");
        tick(97);
        drive_eoc(8'hA5);
        tick(2);
        chk("t6_valid_before", 32'(sample_valid), 32'h0);
        tick(1);
        chk("t6_valid", 32'(sample_valid), 32'h1);
        chk("t6_soc_restart", 32'(adc_soc), 32'h1);
        chk("t6_timeout", 32'(timeout_err), 32'h0);
        chk("t6_count", 32'(sample_count), 32'h1);
        adc_eoc = 1'b0;
        tick(10);
        chk("t6_queue_empty", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 SHALL have parameter DATA_WIDTH_BITS, default 8: ADC sample width.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 3000: clk cycles between successive conversion starts; valid range 16..65535.
REQ-003 SHALL have parameter SOC_WIDTH, default 4: adc_soc high time in clk cycles; valid range 1..SAMPLE_PERIOD/4.
REQ-004 SHALL have parameter EOC_HOLD, default 8: eoc_out high time in clk cycles; valid range 1..SAMPLE_PERIOD/4.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-low; 0 = reset.
REQ-008 Port enable, input, 1: 1 = run conversions; 0 = stop after the current conversion.
REQ-009 Port adc_din, input, DATA_WIDTH_BITS: ADC parallel output; asynchronous to clk.
REQ-010 Port adc_eoc, input, 1: ADC end-of-conversion; asynchronous; active high.
REQ-011 Port adc_soc, output, 1: start-of-conversion pulse to the ADC.
REQ-012 Port sample, output, DATA_WIDTH_BITS: last captured sample.
REQ-013 Port sample_valid, output, 1: one-cycle strobe when sample updates.
REQ-014 Port eoc_out, output, 1: regenerated EOC for the pitch pipeline; high EOC_HOLD cycles per sample.
REQ-015 Port timeout_err, output, 1: sticky flag; set when a conversion times out.
REQ-016 Port sample_count, output, 16: number of samples captured; wraps 65535->0.

Function
REQ-017 SHALL pass adc_eoc and adc_din through two flip-flop stages each; eoc_rise = synchronized eoc is 1 and its previous value is 0.
REQ-018 SHALL implement states IDLE, START, WAIT_EOC, HOLD.
REQ-019 IDLE: adc_soc=0; if enable=1, go to START next cycle and clear the period counter.
REQ-020 START: adc_soc=1 for exactly SOC_WIDTH cycles, then go to WAIT_EOC.
REQ-021 WAIT_EOC: on eoc_rise, latch the synchronized adc_din into sample, pulse sample_valid for 1 cycle, increment sample_count, and go to HOLD.
REQ-022 Latency: sample_valid SHALL assert at most 3 clk cycles after the adc_eoc rising edge.
REQ-023 eoc_out SHALL rise in the same cycle as sample_valid and stay high EOC_HOLD cycles; it SHALL not retrigger while high.
REQ-024 The period counter SHALL count from 0 at entry to START and reach SAMPLE_PERIOD-1 at the last cycle of the period.
REQ-025 HOLD: at period end, go to START if enable=1, else IDLE; consecutive adc_soc rising edges SHALL be exactly SAMPLE_PERIOD cycles apart.
REQ-026 Timeout: if the period ends in WAIT_EOC without eoc_rise, set timeout_err, leave sample/sample_count unchanged, and go to START (enable=1) or IDLE.
REQ-027 An eoc_rise outside WAIT_EOC, including during START, SHALL be ignored: no capture, no count.
REQ-028 eoc_rise and period end in the same cycle in WAIT_EOC: capture wins, no timeout, next state START/IDLE per enable.
REQ-029 enable deasserted mid-conversion SHALL NOT abort it; the block completes the capture or timeout, then goes to IDLE.
REQ-030 timeout_err SHALL clear only by reset.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL enter IDLE, with adc_soc=0, sample=0, sample_valid=0, eoc_out=0, timeout_err=0, sample_count=0, all counters and synchronizers 0.
REQ-032 Reset mid-operation SHALL abort immediately with no partial outputs; first adc_soc at least 1 cycle after reset=1 with enable=1.

Verification
REQ-033 Params 100/4/8, enable=1, ADC model EOC 20 cycles after SOC with din=0x5A -> adc_soc edges every 100 cycles, sample=0x5A, one sample_valid per period, eoc_out high 8 cycles, sample_count increments each period.
REQ-034 ADC model never raises EOC -> timeout_err=1 at cycle 100, adc_soc again at cycle 100, sample_count stays 0.
REQ-035 EOC pulse during START (cycle 2) then a real EOC at cycle 30 with din=0xC3 -> exactly one capture, sample=0xC3.
REQ-036 enable dropped at cycle 10 of a period, EOC at cycle 20 -> sample captured, then IDLE, no further adc_soc.
REQ-037 reset=0 for 1 cycle during WAIT_EOC -> all outputs zero next cycle, restart with a clean 100-cycle period.
REQ-038 EOC timed to eoc_rise on cycle 99 -> capture, timeout_err stays 0.
